// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 write sequencer: FSM states,
// the power-up command list and the slow-command classifier.
package lcd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT  = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_SETUP     = 3'd2,
    ST_EN_HIGH   = 3'd3,
    ST_HOLD      = 3'd4,
    ST_WAIT      = 3'd5,
    ST_IDLE      = 3'd6
  } state_e;

  localparam int INIT_LEN = 6;

  // Entry [0] is issued first: function set x3, display on, clear, entry mode.
  localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
    8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38
  };

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear and return-home (0x02 or 0x03) need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_ctrl_timer.sv
// Loadable down-counter used for every phase duration; saturates at zero.
module lcd_ctrl_timer #(
  parameter int          W       = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: power-up init, then one byte per valid/ready
// transfer with SETUP / EN_HIGH / HOLD / WAIT phases on the LCD pins.
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int SETUP_CYC    = 2,
  parameter int EN_CYC       = 12,
  parameter int HOLD_CYC     = 2,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int PWR_WAIT_CYC = 750000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  // Handshake: a byte transfers on any rising edge where req_valid_i and
  // req_ready_o are both high; req_ready_o depends only on registered state.
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       busy_o,
  output logic       init_done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o,
  output state_e     dbg_state_o
);

  localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, EN_CYC),
                                           max_int(HOLD_CYC, CMD_WAIT_CYC)),
                                   max_int(CLR_WAIT_CYC, PWR_WAIT_CYC));
  localparam int TW = $clog2(MAX_CYC + 1);

  state_e       state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [7:0]   data_q, data_d;
  logic         rs_q, rs_d;
  logic         init_done_q, init_done_d;
  logic         en_q, en_d;
  logic         on_q;
  logic         tmr_load;
  logic [TW-1:0] tmr_val;
  logic         tmr_done;

  lcd_ctrl_timer #(
    .W       (TW),
    .RST_VAL (PWR_WAIT_CYC - 1)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      ST_PWR_WAIT: begin
        if (tmr_done) begin
          idx_d   = 3'd0;
          state_d = ST_INIT_LOAD;
        end
      end
      ST_INIT_LOAD: begin
        data_d   = INIT_ROM[idx_q];
        rs_d     = 1'b0;
        state_d  = ST_SETUP;
        tmr_load = 1'b1;
        tmr_val  = TW'(SETUP_CYC - 1);
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_EN_HIGH;
          tmr_load = 1'b1;
          tmr_val  = TW'(EN_CYC - 1);
        end
      end
      ST_EN_HIGH: begin
        if (tmr_done) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = TW'(HOLD_CYC - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
          tmr_val  = is_slow_cmd(rs_q, data_q) ? TW'(CLR_WAIT_CYC - 1)
                                               : TW'(CMD_WAIT_CYC - 1);
        end
      end
      ST_WAIT: begin
        if (tmr_done) begin
          if (init_done_q) begin
            state_d = ST_IDLE;
          end else if (idx_q == 3'(INIT_LEN - 1)) begin
            init_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_INIT_LOAD;
          end
        end
      end
      ST_IDLE: begin
        if (req_valid_i && init_done_q) begin
          data_d   = req_data_i;
          rs_d     = req_rs_i;
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = TW'(SETUP_CYC - 1);
        end
      end
      default: begin
        state_d = ST_PWR_WAIT;
      end
    endcase

    // Registered strobe avoids decode glitches on the pin.
    en_d = (state_d == ST_EN_HIGH);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_PWR_WAIT;
      idx_q       <= 3'd0;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      init_done_q <= init_done_d;
      en_q        <= en_d;
      on_q        <= 1'b1;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE) && init_done_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign init_done_o = init_done_q;
  assign lcd_data_o  = data_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = en_q;
  assign lcd_on_o    = on_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing: init sequence, table of
// single writes, held-valid burst, and reset asserted mid-strobe.
module tb_lcd_ctrl;

  localparam int SETUP = 2, EN = 3, HOLD = 2, CMDW = 5, CLRW = 9, PWRW = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, busy, init_done;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [2:0] dbg_state;

  lcd_ctrl #(
    .SETUP_CYC    (SETUP),
    .EN_CYC       (EN),
    .HOLD_CYC     (HOLD),
    .CMD_WAIT_CYC (CMDW),
    .CLR_WAIT_CYC (CLRW),
    .PWR_WAIT_CYC (PWRW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (valid),
    .req_ready_o (ready),
    .req_rs_i    (rs),
    .req_data_i  (data),
    .busy_o      (busy),
    .init_done_o (init_done),
    .lcd_data_o  (lcd_data),
    .lcd_rs_o    (lcd_rs),
    .lcd_rw_o    (lcd_rw),
    .lcd_en_o    (lcd_en),
    .lcd_on_o    (lcd_on),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset-relative cycle counter
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  int rise_q[$];
  logic en_prev = 1'b0;
  int rise_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every EN rising edge must carry the next expected {rs,data}
  always @(negedge clk) begin
    if (rst) begin
      en_prev = 1'b0;
    end else begin
      if (lcd_en && !en_prev) begin
        rise_cyc = cyc;
        rise_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got rs=%0b data=%0h expected none", lcd_rs, lcd_data);
        end else begin
          check("pulse_rs_data", {lcd_rs, lcd_data}, exp_q.pop_front());
        end
        check("pulse_rw", lcd_rw, 1'b0);
      end
      if (!lcd_en && en_prev) check("en_width", cyc - rise_cyc, EN);
      en_prev = lcd_en;
    end
  end

  logic [7:0] init_bytes[6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int exp_rise[7] = '{13, 26, 39, 52, 65, 82, 95};

  task automatic check_reset_values(input string tag);
    check({tag, "_en"}, lcd_en, 1'b0);
    check({tag, "_on"}, lcd_on, 1'b0);
    check({tag, "_data"}, lcd_data, 8'h00);
    check({tag, "_rs"}, lcd_rs, 1'b0);
    check({tag, "_rw"}, lcd_rw, 1'b0);
    check({tag, "_ready"}, ready, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_init_done"}, init_done, 1'b0);
  endtask

  // Called with rst high; releases reset and checks the whole init sequence.
  task automatic run_init(input bit with_req, input logic [7:0] req_byte);
    int t;
    int k;
    int n;
    rise_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, init_bytes[i]});
    if (with_req) begin
      exp_q.push_back({1'b1, req_byte});
      valid = 1'b1;
      rs    = 1'b1;
      data  = req_byte;
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("lcd_on_after_release", lcd_on, 1'b1);
    check("ready_during_pwr", ready, 1'b0);
    t = 0;
    while (!init_done && t < 400) begin
      @(negedge clk);
      check("no_accept_before_init", ready && !init_done, 1'b0);
      t++;
    end
    check("init_done_cycle", cyc, 92);
    check("ready_with_init_done", ready, 1'b1);
    n = 6;
    if (with_req) begin
      @(posedge clk);
      #1 k = cyc;
      check("init_req_accept_edge", k, 93);
      @(negedge clk);
      valid = 1'b0;
      check("init_req_data", lcd_data, req_byte);
      check("init_req_rs", lcd_rs, 1'b1);
      t = 0;
      while (!ready && t < 100) begin @(negedge clk); t++; end
      check("init_req_ready_back", cyc, 105);
      n = 7;
    end
    check("init_pulse_count", rise_q.size(), n);
    for (int i = 0; i < rise_q.size() && i < 7; i++) check("init_rise_cycle", rise_q[i], exp_rise[i]);
  endtask

  task automatic send(input logic rs_v, input logic [7:0] d, input int gap);
    int t;
    int k;
    t = 0;
    while (!ready && t < 100) begin @(negedge clk); t++; end
    check("ready_before_send", ready, 1'b1);
    rise_q.delete();
    exp_q.push_back({rs_v, d});
    valid = 1'b1;
    rs    = rs_v;
    data  = d;
    @(posedge clk);
    #1 k = cyc;
    @(negedge clk);
    valid = 1'b0;
    data  = 8'($urandom_range(0, 255));
    rs    = 1'($urandom_range(0, 1));
    check("send_data", lcd_data, d);
    check("send_rs", lcd_rs, rs_v);
    check("send_ready_low", ready, 1'b0);
    check("send_busy", busy, 1'b1);
    t = 0;
    while (!ready && t < 100) begin
      @(negedge clk);
      check("send_data_stable", {lcd_rs, lcd_data}, {rs_v, d});
      t++;
    end
    check("ready_gap", cyc - k, gap);
    check("send_pulse_count", rise_q.size(), 1);
    if (rise_q.size() > 0) check("en_rise_offset", rise_q[0] - k, SETUP);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         gap;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] burst[3] = '{8'h48, 8'h49, 8'h21};

  initial begin
    int t;
    int k;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    vecs[0] = '{1'b1, 8'h41, 12};
    vecs[1] = '{1'b0, 8'h01, 16};
    vecs[2] = '{1'b0, 8'h0C, 12};
    vecs[3] = '{1'b0, 8'h02, 16};
    vecs[4] = '{1'b0, 8'h03, 16};
    vecs[5] = '{1'b1, 8'h01, 12};
    vecs[6] = '{1'b0, 8'h04, 12};
    vecs[7] = '{1'b0, 8'h00, 12};

    #2;
    check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    run_init(1'b0, 8'h00);

    for (int i = 0; i < 8; i++) send(vecs[i].rs, vecs[i].data, vecs[i].gap);

    // Held valid: three characters, input data scrambled while busy
    rise_q.delete();
    for (int j = 0; j < 3; j++) exp_q.push_back({1'b1, burst[j]});
    valid = 1'b1;
    rs    = 1'b1;
    for (int j = 0; j < 3; j++) begin
      t = 0;
      while (!ready && t < 100) begin
        @(negedge clk);
        if (j > 0) check("burst_hold", lcd_data, burst[j-1]);
        data = 8'($urandom_range(0, 255));
        t++;
      end
      data = burst[j];
      @(posedge clk);
      @(negedge clk);
      check("burst_latch", lcd_data, burst[j]);
      data = 8'($urandom_range(0, 255));
    end
    valid = 1'b0;
    t = 0;
    while (!ready && t < 100) begin @(negedge clk); t++; end
    check("burst_pulse_count", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      check("burst_spacing_01", rise_q[1] - rise_q[0], 13);
      check("burst_spacing_12", rise_q[2] - rise_q[1], 13);
    end

    // Reset asserted between clock edges while EN is high
    exp_q.push_back({1'b1, 8'h55});
    valid = 1'b1;
    rs    = 1'b1;
    data  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    t = 0;
    while (!lcd_en && t < 20) begin @(negedge clk); t++; end
    check("mid_en_seen", lcd_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_reset_values("mid");
    check("mid_exp_empty", exp_q.size(), 0);
    @(negedge clk);
    @(negedge clk);
    run_init(1'b1, 8'h5A);

    check("final_exp_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Sequences byte writes to the HD44780-compatible character LCD behind the processor's LCD I/O port.
- Generates RS/RW/EN/data timing, runs the power-up initialisation sequence autonomously, then accepts one character or command at a time from the LSU-side I/O logic over a valid/ready handshake.
- Sits between the memory-mapped LCD register and the board LCD pins.

Parameters:
- SETUP_CYC, 2, cycles RS/data are stable before EN rises (min 1)
- EN_CYC, 12, cycles EN is held high (min 1)
- HOLD_CYC, 2, cycles RS/data are held after EN falls (min 1)
- CMD_WAIT_CYC, 2000, post-write wait for normal commands and characters (min 1)
- CLR_WAIT_CYC, 82000, post-write wait for clear (0x01) and home (0x02/0x03) with RS=0 (min 1)
- PWR_WAIT_CYC, 750000, wait after reset release before the first init write (min 1)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  write request valid
- req_ready_o  out  1  controller can accept a request
- req_rs_i  in  1  0 = command, 1 = character data
- req_data_i  in  8  byte to write
- busy_o  out  1  controller not in IDLE
- init_done_o  out  1  init sequence complete (sticky until reset)
- lcd_data_o  out  8  LCD data bus
- lcd_rs_o  out  1  LCD register select
- lcd_rw_o  out  1  LCD read/write, tied 0 (write only)
- lcd_en_o  out  1  LCD enable strobe
- lcd_on_o  out  1  LCD power/backlight enable

Behaviour:
- Reset is asynchronous and active-high. Clock is clk_i, reset is rst_i.
- While rst_i is high, outputs are forced immediately:
  - state = PWR_WAIT
  - req_ready_o = 0, busy_o = 1, init_done_o = 0
  - lcd_data_o = 0x00, lcd_rs_o = 0, lcd_rw_o = 0, lcd_en_o = 0, lcd_on_o = 0
- lcd_on_o is 1 from the first clock edge after reset release.
- States: PWR_WAIT, INIT_LOAD, SETUP, EN_HIGH, HOLD, WAIT, IDLE.
- PWR_WAIT:
  - Lasts PWR_WAIT_CYC cycles, then goes to INIT_LOAD with init index = 0.
- INIT_LOAD:
  - Latches init_rom[idx] with RS = 0 into the output regs.
  - Goes to SETUP.
  - Init ROM contents: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- SETUP: en = 0 for SETUP_CYC cycles.
- EN_HIGH: en = 1 for EN_CYC cycles.
- HOLD: en = 0 for HOLD_CYC cycles.
- WAIT:
  - Lasts CLR_WAIT_CYC cycles if RS = 0 and byte is in 0x01..0x03, else CMD_WAIT_CYC.
- End of WAIT:
  - During init, if idx < 5: idx++ and go to INIT_LOAD.
  - If idx = 5: set init_done_o and go to IDLE.
  - Otherwise go to IDLE.
- IDLE:
  - req_ready_o = init_done_o. It is combinational from state, registered elsewhere.
  - Transfer occurs on an edge where req_valid_i && req_ready_o.
  - On transfer, req_rs_i/req_data_i are latched into lcd_rs_o/lcd_data_o at that edge, and state goes to SETUP.
- Cycle timing, with acceptance at edge k:
  - lcd_en_o rises at edge k+SETUP_CYC.
  - lcd_en_o falls at edge k+SETUP_CYC+EN_CYC.
  - req_ready_o reasserts at edge k+SETUP_CYC+EN_CYC+HOLD_CYC+WAIT.
- lcd_data_o/lcd_rs_o change only on acceptance or INIT_LOAD. Input changes while busy are ignored.
- req_ready_o is 0 in every state other than IDLE, so there is no back-to-back acceptance without the full gap.
- No request is accepted before init_done_o.
- lcd_data_o/lcd_rs_o hold their last value in IDLE.
- Timer:
  - Single down-counter, width $clog2(max parameter + 1).
  - Loaded with N-1 on state entry; state exits when count = 0.
  - No wrap-around is permitted.
- Reset asserted mid-operation: EN drops asynchronously, init_done_o clears, and the full power-up sequence reruns.

Decomposition:
- lcd_ctrl_pkg:
  - state_e enum
  - INIT_LEN = 6
  - init ROM constant array
  - command codes CMD_CLEAR = 0x01, CMD_HOME = 0x02
  - helper function is_slow_cmd(rs, data)
- Sub-module lcd_ctrl_timer: load value, load strobe, done flag. Parameterised width.

Test Plan (benches override SETUP=2, EN=3, HOLD=2, CMD_WAIT=5, CLR_WAIT=9, PWR_WAIT=10):
- Reset release:
  - lcd_en_o stays 0 for 10 cycles.
  - Then 6 EN pulses, each 3 cycles wide, RS=0, data 38,38,38,0C,01,06.
  - Gap after 0x01 is 9 wait cycles, others 5.
  - init_done_o rises with req_ready_o after the last wait.
- Char write rs=1, data=0x41 accepted at edge k:
  - lcd_data_o=0x41 and lcd_rs_o=1 from k.
  - EN high on edges k+2..k+5.
  - req_ready_o returns at k+12.
- Command rs=0, data=0x01:
  - req_ready_o returns 16 cycles after acceptance.
  - Command rs=0, data=0x0C returns after 12.
- req_valid_i held high with 3 chars 0x48, 0x49, 0x21, and req_data_i toggled while busy:
  - Exactly 3 EN pulses in order.
  - lcd_data_o never changes between acceptances.
- req_valid_i high during init:
  - No acceptance before init_done_o.
  - The request completes immediately after.
- rst_i pulsed during EN_HIGH of a user write:
  - lcd_en_o and all outputs go to reset values without waiting for a clock edge.
  - Power-up and init sequence repeats identically.
